// File: rtl/edid_pkg.sv
// Shared definitions for the EDID block reader: i2c controller opcodes, DDC addresses,
// FSM state encodings and the byte offsets of the first detailed timing descriptor.
package edid_pkg;

  localparam logic [1:0] I2C_INST_START = 2'd0;
  localparam logic [1:0] I2C_INST_STOP  = 2'd1;
  localparam logic [1:0] I2C_INST_READ  = 2'd2;
  localparam logic [1:0] I2C_INST_WRITE = 2'd3;

  localparam logic [7:0] DDC_ADDR_W = 8'hA0;
  localparam logic [7:0] DDC_ADDR_R = 8'hA1;

  localparam logic [63:0] EDID_HEADER      = 64'h00FF_FFFF_FFFF_FF00;
  localparam int          EDID_BLOCK_BYTES = 128;

  localparam int DTD_PCLK_LO = 54;
  localparam int DTD_PCLK_HI = 55;
  localparam int DTD_HACT_LO = 56;
  localparam int DTD_HACT_HI = 58;
  localparam int DTD_VACT_LO = 59;
  localparam int DTD_VACT_HI = 61;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_START_W = 4'd1,
    S_DEV_W   = 4'd2,
    S_OFFS    = 4'd3,
    S_START_R = 4'd4,
    S_DEV_R   = 4'd5,
    S_READ    = 4'd6,
    S_STOP    = 4'd7,
    S_CHECK   = 4'd8,
    S_DONE    = 4'd9
  } state_e;

  // Header byte idx, counted from the first byte on the wire.
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
    return EDID_HEADER[8*(7 - int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/edid_block_reader_buffer.sv
// EDID byte store: one write port fed by the fetch FSM, one registered read port for the text engine.
module edid_block_reader_buffer #(
  parameter int DEPTH   = 128,
  parameter int RADDR_W = 8,
  parameter int WADDR_W = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [WADDR_W-1:0] waddr_i,
  input  logic [7:0]         wdata_i,
  input  logic [RADDR_W-1:0] raddr_i,
  output logic [7:0]         rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Addresses beyond the buffer read back as zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= 8'h00;
    end else if (int'(raddr_i) < DEPTH) begin
      rdata_q <= mem_q[raddr_i[WADDR_W-1:0]];
    end else begin
      rdata_q <= 8'h00;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/edid_block_reader.sv
// EDID fetch engine: reads NUM_BYTES from DDC slave 0x50 through the byte-level i2c controller,
// validates header and block checksums with automatic retry, and decodes the first DTD.
module edid_block_reader
  import edid_pkg::*;
#(
  parameter int NUM_BYTES    = 128,
  parameter int START_OFFSET = 0,
  parameter int MAX_RETRIES  = 2,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic              err,
  output logic [1:0]        i2c_instruction,
  output logic              i2c_enable,
  output logic [7:0]        i2c_byte_to_send,
  input  logic [7:0]        i2c_byte_received,
  input  logic              i2c_complete,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [15:0]       pixel_clk_10k,
  output logic [11:0]       h_active,
  output logic [11:0]       v_active
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int BUF_AW = $clog2(NUM_BYTES);

  state_e             state_q, next_d;
  logic               rel_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         retries_q;
  logic [7:0]         sum0_q, sum1_q;
  logic               hdr_ok_q;
  logic               busy_q, done_q, valid_q, err_q, en_q;
  logic [1:0]         inst_q, inst_d;
  logic [7:0]         tx_q, tx_d;
  logic               wr_en_q;
  logic [BUF_AW-1:0]  wr_addr_q;
  logic [7:0]         wr_data_q;
  logic [15:0]        pclk_q;
  logic [11:0]        hact_q, vact_q;
  logic               pass_s;

  assign pass_s = (hdr_ok_q || (START_OFFSET != 0)) && (sum0_q == 8'h00) &&
                  ((NUM_BYTES <= EDID_BLOCK_BYTES) || (sum1_q == 8'h00));

  always_comb begin
    inst_d = I2C_INST_START;
    tx_d   = 8'h00;
    next_d = state_q;
    case (state_q)
      S_START_W: next_d = S_DEV_W;
      S_DEV_W: begin
        inst_d = I2C_INST_WRITE;
        tx_d   = DDC_ADDR_W;
        next_d = S_OFFS;
      end
      S_OFFS: begin
        inst_d = I2C_INST_WRITE;
        tx_d   = 8'(START_OFFSET);
        next_d = S_START_R;
      end
      S_START_R: next_d = S_DEV_R;
      S_DEV_R: begin
        inst_d = I2C_INST_WRITE;
        tx_d   = DDC_ADDR_R;
        next_d = S_READ;
      end
      S_READ: begin
        inst_d = I2C_INST_READ;
        next_d = (cnt_q == CNT_W'(NUM_BYTES)) ? S_STOP : S_READ;
      end
      S_STOP: begin
        inst_d = I2C_INST_STOP;
        next_d = S_CHECK;
      end
      default: next_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rel_q     <= 1'b0;
      cnt_q     <= '0;
      retries_q <= 3'd0;
      sum0_q    <= 8'h00;
      sum1_q    <= 8'h00;
      hdr_ok_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      en_q      <= 1'b0;
      inst_q    <= 2'd0;
      tx_q      <= 8'h00;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      pclk_q    <= 16'h0000;
      hact_q    <= 12'h000;
      vact_q    <= 12'h000;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q    <= 1'b1;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            retries_q <= 3'd0;
            sum0_q    <= 8'h00;
            sum1_q    <= 8'h00;
            hdr_ok_q  <= 1'b1;
            cnt_q     <= '0;
            rel_q     <= 1'b0;
            state_q   <= S_START_W;
          end
        end
        S_START_W, S_DEV_W, S_OFFS, S_START_R, S_DEV_R, S_READ, S_STOP: begin
          // Hold the request until complete, then wait for complete to fall before moving on.
          if (!rel_q) begin
            en_q   <= 1'b1;
            inst_q <= inst_d;
            tx_q   <= tx_d;
            if (en_q && i2c_complete) begin
              en_q  <= 1'b0;
              rel_q <= 1'b1;
              if (state_q == S_READ) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= cnt_q[BUF_AW-1:0];
                wr_data_q <= i2c_byte_received;
                cnt_q     <= cnt_q + CNT_W'(1);
                if (cnt_q < CNT_W'(EDID_BLOCK_BYTES)) begin
                  sum0_q <= sum0_q + i2c_byte_received;
                end else begin
                  sum1_q <= sum1_q + i2c_byte_received;
                end
                if ((cnt_q < CNT_W'(8)) && (i2c_byte_received != hdr_byte(cnt_q[2:0]))) begin
                  hdr_ok_q <= 1'b0;
                end
                if (cnt_q == CNT_W'(DTD_PCLK_LO)) pclk_q[7:0]  <= i2c_byte_received;
                if (cnt_q == CNT_W'(DTD_PCLK_HI)) pclk_q[15:8] <= i2c_byte_received;
                if (cnt_q == CNT_W'(DTD_HACT_LO)) hact_q[7:0]  <= i2c_byte_received;
                if (cnt_q == CNT_W'(DTD_HACT_HI)) hact_q[11:8] <= i2c_byte_received[7:4];
                if (cnt_q == CNT_W'(DTD_VACT_LO)) vact_q[7:0]  <= i2c_byte_received;
                if (cnt_q == CNT_W'(DTD_VACT_HI)) vact_q[11:8] <= i2c_byte_received[7:4];
              end
            end
          end else if (!i2c_complete) begin
            rel_q   <= 1'b0;
            state_q <= next_d;
          end
        end
        S_CHECK: begin
          if (pass_s) begin
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end else if (retries_q < 3'(MAX_RETRIES)) begin
            retries_q <= retries_q + 3'd1;
            sum0_q    <= 8'h00;
            sum1_q    <= 8'h00;
            hdr_ok_q  <= 1'b1;
            cnt_q     <= '0;
            rel_q     <= 1'b0;
            state_q   <= S_START_W;
          end else begin
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  edid_block_reader_buffer #(
    .DEPTH   (NUM_BYTES),
    .RADDR_W (ADDR_W),
    .WADDR_W (BUF_AW)
  ) u_buffer (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_en_q),
    .waddr_i (wr_addr_q),
    .wdata_i (wr_data_q),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  assign busy             = busy_q;
  assign done             = done_q;
  assign valid            = valid_q;
  assign err              = err_q;
  assign i2c_instruction  = inst_q;
  assign i2c_enable       = en_q;
  assign i2c_byte_to_send = tx_q;
  assign pixel_clk_10k    = pclk_q;
  assign h_active         = hact_q;
  assign v_active         = vact_q;

endmodule
